// File: rtl/uart_framed_transceiver.sv
// uart_framed_transceiver: full-duplex UART with programmable framing
// (5..8 data bits, 1 or 2 stop bits, optional parity).
// RX and TX run from a shared oversample tick; each bit lasts
// 2**OVERSAMPLE_LOG2 ticks.
// Optional macro UART_PARITY_EN: when defined, parity generation and checking
// are built in. When it is undefined, cfg_parity_en/cfg_parity_odd are ignored
// and rx_parity_err stays 0.
// The break strobe is named rx_break because 'break' is a reserved word.
module uart_framed_transceiver #(
    parameter int DIV_WIDTH       = 16,
    parameter int OVERSAMPLE_LOG2 = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic [1:0]           cfg_databits,
    input  logic                 cfg_stop2,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd,
    output logic [7:0]           rx_data,
    output logic                 rx_done,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_break,
    input  logic [7:0]           tx_data,
    input  logic                 tx_wr,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int PW = OVERSAMPLE_LOG2;
    localparam logic [PW-1:0] PH_LAST = '1;
    localparam logic [PW-1:0] PH_MID  = {1'b1, {(PW-1){1'b0}}};
    localparam logic [PW-1:0] PH_PRE  = PH_MID - 1'b1;
    localparam logic [PW-1:0] PH_POST = PH_MID + 1'b1;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic                 tick;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    state_t               rx_state_q, tx_state_q;
    logic [PW-1:0]        rx_phase_q, tx_phase_q;
    logic [2:0]           rx_idx_q, rx_last_q, tx_idx_q, tx_last_q;
    logic [1:0]           rx_samp_q;
    logic [7:0]           rx_shift_q, tx_shift_q;
    logic                 tx_stop2_q, tx_stop_second_q;
    logic                 rx_bit, rx_decide, rx_bit_end, tx_bit_end;
    logic [2:0]           cfg_last_d;

`ifdef UART_PARITY_EN
    logic       rx_par_en_q, rx_par_odd_q, rx_pbit_q;
    logic       tx_par_en_q, tx_par_bit_q;
    logic [7:0] tx_mask_d;
    assign tx_mask_d = 8'hFF >> (2'd3 - cfg_databits);
`else
    logic unused_cfg;
    assign unused_cfg = cfg_parity_en ^ cfg_parity_odd;
`endif

    // Index of the last data bit: 5..8 bits -> 4..7
    assign cfg_last_d = {1'b0, cfg_databits} + 3'd4;
    assign tick       = (div_cnt_q == '0);
    // 2-of-3 majority of the samples at phases M-1, M and M+1
    assign rx_bit     = (rx_samp_q[0] & rx_samp_q[1]) | (rx_samp_q[0] & rx_sync_q) | (rx_samp_q[1] & rx_sync_q);
    assign rx_decide  = tick && (rx_phase_q == PH_POST);
    assign rx_bit_end = tick && (rx_phase_q == PH_LAST);
    assign tx_bit_end = tick && (tx_phase_q == PH_LAST);

    // Oversample tick divider: reloads divisor-1 whenever it reaches zero
    always_ff @(posedge sys_clk) begin
        if (sys_rst || div_cnt_q == '0) div_cnt_q <= divisor - 1'b1;
        else                            div_cnt_q <= div_cnt_q - 1'b1;
    end

    // Two-flop synchroniser plus a per-tick copy for falling-edge detection
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            if (tick) rx_prev_q <= rx_sync_q;
        end
    end

    // Receive FSM; returns to IDLE at the first stop bit's decision phase
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_state_q    <= S_IDLE;
            rx_phase_q    <= '0;
            rx_idx_q      <= '0;
            rx_last_q     <= '0;
            rx_samp_q     <= 2'b11;
            rx_shift_q    <= '0;
            rx_data       <= '0;
            rx_done       <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_break      <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_en_q   <= 1'b0;
            rx_par_odd_q  <= 1'b0;
            rx_pbit_q     <= 1'b0;
`endif
        end else begin
            rx_done      <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_break     <= 1'b0;
            if (tick && rx_state_q != S_IDLE) begin
                rx_phase_q <= rx_phase_q + 1'b1;
                if (rx_phase_q == PH_PRE) rx_samp_q[0] <= rx_sync_q;
                if (rx_phase_q == PH_MID) rx_samp_q[1] <= rx_sync_q;
            end
            case (rx_state_q)
                S_IDLE: if (tick && rx_prev_q && !rx_sync_q) begin
                    rx_state_q <= S_START;
                    rx_phase_q <= '0;
                    rx_idx_q   <= '0;
                    rx_shift_q <= '0;
                    rx_last_q  <= cfg_last_d;
`ifdef UART_PARITY_EN
                    rx_par_en_q  <= cfg_parity_en;
                    rx_par_odd_q <= cfg_parity_odd;
                    rx_pbit_q    <= 1'b0;
`endif
                end
                S_START: begin
                    if (rx_decide && rx_bit) rx_state_q <= S_IDLE;
                    else if (rx_bit_end)     rx_state_q <= S_DATA;
                end
                S_DATA: begin
                    if (rx_decide) rx_shift_q[rx_idx_q] <= rx_bit;
                    if (rx_bit_end) begin
                        if (rx_idx_q == rx_last_q) begin
`ifdef UART_PARITY_EN
                            rx_state_q <= rx_par_en_q ? S_PARITY : S_STOP;
`else
                            rx_state_q <= S_STOP;
`endif
                        end else begin
                            rx_idx_q <= rx_idx_q + 1'b1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (rx_decide)  rx_pbit_q  <= rx_bit;
                    if (rx_bit_end) rx_state_q <= S_STOP;
                end
`endif
                S_STOP: if (rx_decide) begin
                    rx_state_q <= S_IDLE;
                    if (rx_bit) begin
                        rx_data <= rx_shift_q;
                        rx_done <= 1'b1;
`ifdef UART_PARITY_EN
                        rx_parity_err <= rx_par_en_q & (^rx_shift_q ^ rx_pbit_q ^ rx_par_odd_q);
`else
                        rx_parity_err <= 1'b0;
`endif
                    end else begin
                        rx_frame_err <= 1'b1;
`ifdef UART_PARITY_EN
                        rx_break <= (rx_shift_q == 8'd0) && !(rx_par_en_q && rx_pbit_q);
`else
                        rx_break <= (rx_shift_q == 8'd0);
`endif
                    end
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    // Transmit FSM; a write is only accepted in IDLE, on any cycle
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_state_q       <= S_IDLE;
            tx_phase_q       <= '0;
            tx_idx_q         <= '0;
            tx_last_q        <= '0;
            tx_shift_q       <= '0;
            tx_stop2_q       <= 1'b0;
            tx_stop_second_q <= 1'b0;
            uart_tx          <= 1'b1;
            tx_busy          <= 1'b0;
            tx_done          <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_en_q      <= 1'b0;
            tx_par_bit_q     <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (tick && tx_state_q != S_IDLE) tx_phase_q <= tx_phase_q + 1'b1;
            case (tx_state_q)
                S_IDLE: if (tx_wr) begin
                    tx_state_q       <= S_START;
                    tx_phase_q       <= '0;
                    tx_idx_q         <= '0;
                    tx_last_q        <= cfg_last_d;
                    tx_shift_q       <= tx_data;
                    tx_stop2_q       <= cfg_stop2;
                    tx_stop_second_q <= 1'b0;
                    uart_tx          <= 1'b0;
                    tx_busy          <= 1'b1;
`ifdef UART_PARITY_EN
                    tx_par_en_q      <= cfg_parity_en;
                    tx_par_bit_q     <= ^(tx_data & tx_mask_d) ^ cfg_parity_odd;
`endif
                end
                S_START: if (tx_bit_end) begin
                    tx_state_q <= S_DATA;
                    uart_tx    <= tx_shift_q[0];
                end
                S_DATA: if (tx_bit_end) begin
                    if (tx_idx_q == tx_last_q) begin
`ifdef UART_PARITY_EN
                        tx_state_q <= tx_par_en_q ? S_PARITY : S_STOP;
                        uart_tx    <= tx_par_en_q ? tx_par_bit_q : 1'b1;
`else
                        tx_state_q <= S_STOP;
                        uart_tx    <= 1'b1;
`endif
                    end else begin
                        tx_idx_q   <= tx_idx_q + 1'b1;
                        tx_shift_q <= tx_shift_q >> 1;
                        uart_tx    <= tx_shift_q[1];
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: if (tx_bit_end) begin
                    tx_state_q <= S_STOP;
                    uart_tx    <= 1'b1;
                end
`endif
                S_STOP: if (tx_bit_end) begin
                    if (tx_stop2_q && !tx_stop_second_q) begin
                        tx_stop_second_q <= 1'b1;
                    end else begin
                        tx_state_q <= S_IDLE;
                        tx_busy    <= 1'b0;
                        tx_done    <= 1'b1;
                    end
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end
endmodule
